// File: rtl/sprite_pkg.sv
// Shared constants and IDs for the sprite datapath.
// Holds requester indices into the shared sprite ROM, sizing constants,
// the transparent pixel colour and a small index-width helper.
package sprite_pkg;

  localparam int N_SPRITE_REQ  = 4;
  localparam int SPRITE_ADDR_W = 16;
  localparam int PIXEL_W       = 12;

  typedef enum logic [1:0] {
    REQ_PLAYER  = 2'd0,
    REQ_MOON    = 2'd1,
    REQ_HECATIA = 2'd2,
    REQ_LASER   = 2'd3
  } sprite_req_e;

  // RGB444 colour key that sprite units treat as "no pixel".
  localparam logic [PIXEL_W-1:0] PIXEL_TRANSPARENT = 12'hF0F;

  // Width of an index into n items; never zero so ports stay legal at n=1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Scans req_i starting at ptr_i, wrapping modulo N; the first set bit wins.
// Ports:
//   req_i  [N]  request vector
//   ptr_i  [IW] scan start index
//   gnt_o  [N]  one-hot grant (0 when no request)
//   win_o  [IW] index of the winner (0 when no request)
//   any_o       a winner exists
module rr_arbiter
  import sprite_pkg::*;
#(
  parameter int   N  = 4,
  localparam int  IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] win_o,
  output logic          any_o
);

  int   idx;
  logic found;

  always_comb begin
    gnt_o = '0;
    win_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        win_o      = IW'(idx);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one single-port sprite ROM among N_REQ requesters.
// Round-robin grant (combinational), registered ROM address stage, and a
// tag/valid pipeline that routes each returned pixel word back to the
// requester that asked for it. Throughput one read per clock, no back-pressure.
// Ports:
//   clk, rstn          clock, async active-low reset
//   hold               1 = issue no new grants (in-flight reads still finish)
//   req  [N_REQ]       per-requester level request
//   addr [N_REQ*ADDR_W] flattened addresses, slice i = [i*ADDR_W +: ADDR_W]
//   gnt  [N_REQ]       one-hot combinational grant
//   rom_en, rom_addr   registered ROM read strobe/address
//   rom_data           ROM output, valid ROM_LAT cycles after rom_en
//   rd_valid [N_REQ]   one-hot registered completion pulse
//   rd_data            registered pixel word, qualified by rd_valid
// ROM_LAT must be at least 1.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int N_REQ   = N_SPRITE_REQ,
  parameter int ADDR_W  = SPRITE_ADDR_W,
  parameter int DATA_W  = PIXEL_W,
  parameter int ROM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    hold,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]        gnt,
  output logic                    rom_en,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [N_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]       rd_data
);

  localparam int IW = idx_w(N_REQ);

  logic [N_REQ-1:0][ADDR_W-1:0] addr_v;
  logic [N_REQ-1:0]             cand, arb_gnt, tag_oh;
  logic [IW-1:0]                win, rr_q, rr_d;
  logic                         any, grant;

  // Stage 0 is the issue register (its valid is rom_en); stage ROM_LAT lines
  // up with rom_data for the same read.
  logic [ROM_LAT:0]             vld_pipe_q;
  logic [ROM_LAT:0][IW-1:0]     tag_pipe_q;
  logic [ADDR_W-1:0]            rom_addr_q;
  logic [N_REQ-1:0]             rd_valid_q;
  logic [DATA_W-1:0]            rd_data_q;

  assign addr_v = addr;
  assign cand   = req & {N_REQ{~hold}};

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req_i (cand),
    .ptr_i (rr_q),
    .gnt_o (arb_gnt),
    .win_o (win),
    .any_o (any)
  );

  // Grant is suppressed during reset so no requester drops its request for
  // a read that the reset is about to discard.
  assign gnt   = arb_gnt & {N_REQ{rstn}};
  assign grant = any & rstn;

  // Pointer moves past the winner, so a requester holding req re-queues
  // behind everyone else.
  always_comb begin
    rr_d = rr_q;
    if (grant) rr_d = (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
  end

  always_comb begin
    tag_oh = '0;
    tag_oh[tag_pipe_q[ROM_LAT]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_q       <= '0;
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
      rom_addr_q <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      rr_q       <= rr_d;
      vld_pipe_q <= {vld_pipe_q[ROM_LAT-1:0], grant};
      tag_pipe_q <= {tag_pipe_q[ROM_LAT-1:0], win};
      if (grant) rom_addr_q <= addr_v[win];
      rd_valid_q <= vld_pipe_q[ROM_LAT] ? tag_oh : '0;
      if (vld_pipe_q[ROM_LAT]) rd_data_q <= rom_data;
    end
  end

  assign rom_en   = vld_pipe_q[0];
  assign rom_addr = rom_addr_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: three instances (ROM_LAT 1,2,3) share one
// stimulus stream. A hand-computed vector table checks the LAT=1 instance;
// a small reference model checks all instances every cycle.
module tb_sprite_rom_arbiter;

  localparam logic [63:0] A1 = {16'h3333, 16'h2222, 16'h1111, 16'h0123};
  localparam logic [63:0] A2 = {16'h3333, 16'h2222, 16'h1111, 16'h0AAA};

  logic        clk = 1'b0;
  logic        rstn, hold;
  logic [3:0]  req;
  logic [63:0] addr;

  logic [3:0]  gnt_w  [3];
  logic        en_w   [3];
  logic [15:0] radr_w [3];
  logic [11:0] rom_w  [3];
  logic [3:0]  rdv_w  [3];
  logic [11:0] rdd_w  [3];

  always #5 clk = ~clk;

  sprite_rom_arbiter #(.ROM_LAT(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .hold(hold), .req(req), .addr(addr), .gnt(gnt_w[0]),
    .rom_en(en_w[0]), .rom_addr(radr_w[0]), .rom_data(rom_w[0]),
    .rd_valid(rdv_w[0]), .rd_data(rdd_w[0]));
  sprite_rom_arbiter #(.ROM_LAT(2)) u_dut2 (
    .clk(clk), .rstn(rstn), .hold(hold), .req(req), .addr(addr), .gnt(gnt_w[1]),
    .rom_en(en_w[1]), .rom_addr(radr_w[1]), .rom_data(rom_w[1]),
    .rd_valid(rdv_w[1]), .rd_data(rdd_w[1]));
  sprite_rom_arbiter #(.ROM_LAT(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .hold(hold), .req(req), .addr(addr), .gnt(gnt_w[2]),
    .rom_en(en_w[2]), .rom_addr(radr_w[2]), .rom_data(rom_w[2]),
    .rd_valid(rdv_w[2]), .rd_data(rdd_w[2]));

  function automatic logic [11:0] rom_f(input logic [15:0] a);
    return a[11:0] ^ {a[15:12], 8'hA5};
  endfunction

  // ROM models: instance i has latency i+1.
  logic [11:0] rp [3][3];
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (en_w[i]) rp[i][0] <= rom_f(radr_w[i]);
      for (int k = 1; k < 3; k++) rp[i][k] <= rp[i][k-1];
    end
  end
  assign rom_w[0] = rp[0][0];
  assign rom_w[1] = rp[1][1];
  assign rom_w[2] = rp[2][2];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model state.
  int          rr_m;
  logic        vm     [3][4];
  int          tm     [3][4];
  logic [15:0] am     [3][4];
  logic [15:0] addr_m [3];
  logic [3:0]  rdv_m  [3];
  logic [11:0] rdd_m  [3];

  task automatic model_reset();
    rr_m = 0;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) begin vm[i][k] = 1'b0; tm[i][k] = 0; am[i][k] = '0; end
      addr_m[i] = '0; rdv_m[i] = '0; rdd_m[i] = '0;
    end
  endtask

  // Called at the negedge: compares every instance, then advances the model
  // to what the coming posedge should produce.
  task automatic model_check();
    logic [3:0]  cand, eg;
    logic [15:0] wa;
    int          win, j, L;
    if (!rstn) model_reset();
    eg = '0; win = 0;
    if (rstn) begin
      cand = req & ~{4{hold}};
      for (int k = 0; k < 4; k++) begin
        j = (rr_m + k) % 4;
        if (eg == 4'h0 && cand[j]) begin eg = 4'(1 << j); win = j; end
      end
    end
    wa = addr[win*16 +: 16];
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_gnt_L%0d", i+1), 32'(gnt_w[i]), 32'(eg));
      chk($sformatf("model_rom_en_L%0d", i+1), 32'(en_w[i]), 32'(vm[i][0]));
      chk($sformatf("model_rom_addr_L%0d", i+1), 32'(radr_w[i]), 32'(addr_m[i]));
      chk($sformatf("model_rd_valid_L%0d", i+1), 32'(rdv_w[i]), 32'(rdv_m[i]));
      chk($sformatf("model_rd_data_L%0d", i+1), 32'(rdd_w[i]), 32'(rdd_m[i]));
    end
    if (rstn) begin
      for (int i = 0; i < 3; i++) begin
        L = i + 1;
        rdv_m[i] = vm[i][L] ? 4'(1 << tm[i][L]) : 4'h0;
        if (vm[i][L]) rdd_m[i] = rom_f(am[i][L]);
        for (int k = L; k >= 1; k--) begin
          vm[i][k] = vm[i][k-1]; tm[i][k] = tm[i][k-1]; am[i][k] = am[i][k-1];
        end
        vm[i][0] = (eg != 4'h0); tm[i][0] = win; am[i][0] = wa;
        if (eg != 4'h0) addr_m[i] = wa;
      end
      if (eg != 4'h0) rr_m = (win + 1) % 4;
    end
  endtask

  task automatic step(input logic r, input logic h, input logic [3:0] q, input logic [63:0] a);
    @(posedge clk);
    #1;
    rstn = r; hold = h; req = q; addr = a;
    @(negedge clk);
    model_check();
  endtask

  typedef struct {
    logic        rstn;
    logic        hold;
    logic [3:0]  req;
    logic [63:0] addr;
    logic [3:0]  gnt;
    logic        en;
    logic [15:0] radr;
    logic [3:0]  rdv;
    logic [11:0] rdd;
  } vec_t;

  vec_t tq[$];

  task automatic vec(input logic r, input logic h, input logic [3:0] q, input logic [63:0] a,
                     input logic [3:0] g, input logic e, input logic [15:0] ra,
                     input logic [3:0] rv, input logic [11:0] rd);
    vec_t v;
    v = '{r, h, q, a, g, e, ra, rv, rd};
    tq.push_back(v);
  endtask

  initial begin
    int cnt [3];
    int first [3];
    logic [3:0] eg;

    rstn = 1'b0; hold = 1'b0; req = '0; addr = A1;
    model_reset();

    // rstn hold req addr | gnt en rom_addr rd_valid rd_data
    // single read, latency 3
    vec(0,0,4'b0000,A1, 4'b0000,0,16'h0000,4'b0000,12'h000);
    vec(1,0,4'b0001,A1, 4'b0001,0,16'h0000,4'b0000,12'h000);
    vec(1,0,4'b0000,A1, 4'b0000,1,16'h0123,4'b0000,12'h000);
    vec(1,0,4'b0000,A1, 4'b0000,0,16'h0123,4'b0000,12'h000);
    vec(1,0,4'b0000,A1, 4'b0000,0,16'h0123,4'b0001,12'h186);
    vec(1,0,4'b0000,A2, 4'b0000,0,16'h0123,4'b0000,12'h186);
    // req 0101 with rr=1: 0100 then 0001
    vec(1,0,4'b0101,A2, 4'b0100,0,16'h0123,4'b0000,12'h186);
    vec(1,0,4'b0001,A2, 4'b0001,1,16'h2222,4'b0000,12'h186);
    vec(1,0,4'b0000,A2, 4'b0000,1,16'h0AAA,4'b0000,12'h186);
    vec(1,0,4'b0000,A2, 4'b0000,0,16'h0AAA,4'b0100,12'h087);
    vec(1,0,4'b0000,A2, 4'b0000,0,16'h0AAA,4'b0001,12'hA0F);
    vec(1,0,4'b0000,A2, 4'b0000,0,16'h0AAA,4'b0000,12'hA0F);
    // hold after a grant: pending read completes, grants resume at rr
    vec(1,0,4'b1111,A2, 4'b0010,0,16'h0AAA,4'b0000,12'hA0F);
    vec(1,1,4'b1101,A2, 4'b0000,1,16'h1111,4'b0000,12'hA0F);
    vec(1,1,4'b1101,A2, 4'b0000,0,16'h1111,4'b0000,12'hA0F);
    vec(1,1,4'b1101,A2, 4'b0000,0,16'h1111,4'b0010,12'h0B4);
    vec(1,0,4'b1101,A2, 4'b0100,0,16'h1111,4'b0000,12'h0B4);
    vec(1,0,4'b1001,A2, 4'b1000,1,16'h2222,4'b0000,12'h0B4);
    vec(1,0,4'b0001,A2, 4'b0001,1,16'h3333,4'b0000,12'h0B4);
    vec(1,0,4'b0000,A2, 4'b0000,1,16'h0AAA,4'b0100,12'h087);
    vec(1,0,4'b0000,A2, 4'b0000,0,16'h0AAA,4'b1000,12'h096);
    vec(1,0,4'b0000,A2, 4'b0000,0,16'h0AAA,4'b0001,12'hA0F);
    vec(1,0,4'b0000,A2, 4'b0000,0,16'h0AAA,4'b0000,12'hA0F);
    // reset one cycle after a grant: read discarded, rr back to 0
    vec(1,0,4'b1111,A2, 4'b0010,0,16'h0AAA,4'b0000,12'hA0F);
    vec(0,0,4'b1111,A2, 4'b0000,0,16'h0000,4'b0000,12'h000);
    vec(1,0,4'b0000,A2, 4'b0000,0,16'h0000,4'b0000,12'h000);
    vec(1,0,4'b0000,A2, 4'b0000,0,16'h0000,4'b0000,12'h000);
    vec(1,0,4'b0000,A2, 4'b0000,0,16'h0000,4'b0000,12'h000);
    vec(1,0,4'b1111,A2, 4'b0001,0,16'h0000,4'b0000,12'h000);
    vec(1,0,4'b1110,A2, 4'b0010,1,16'h0AAA,4'b0000,12'h000);
    vec(1,0,4'b0000,A2, 4'b0000,1,16'h1111,4'b0000,12'h000);
    vec(1,0,4'b0000,A2, 4'b0000,0,16'h1111,4'b0001,12'hA0F);
    vec(1,0,4'b0000,A2, 4'b0000,0,16'h1111,4'b0010,12'h0B4);
    vec(1,0,4'b0000,A2, 4'b0000,0,16'h1111,4'b0000,12'h0B4);

    foreach (tq[i]) begin
      step(tq[i].rstn, tq[i].hold, tq[i].req, tq[i].addr);
      chk($sformatf("vec%0d_gnt", i), 32'(gnt_w[0]), 32'(tq[i].gnt));
      chk($sformatf("vec%0d_rom_en", i), 32'(en_w[0]), 32'(tq[i].en));
      chk($sformatf("vec%0d_rom_addr", i), 32'(radr_w[0]), 32'(tq[i].radr));
      chk($sformatf("vec%0d_rd_valid", i), 32'(rdv_w[0]), 32'(tq[i].rdv));
      chk($sformatf("vec%0d_rd_data", i), 32'(rdd_w[0]), 32'(tq[i].rdd));
    end

    // All four requesting for 8 cycles after reset, every latency.
    step(0, 0, 4'b0000, A2);
    for (int i = 0; i < 3; i++) begin cnt[i] = 0; first[i] = -1; end
    for (int c = 0; c < 14; c++) begin
      step(1, 0, (c < 8) ? 4'b1111 : 4'b0000, A2);
      if (c < 8) begin
        eg = 4'(1 << (c % 4));
        chk($sformatf("rr8_gnt_c%0d", c), 32'(gnt_w[0]), 32'(eg));
      end
      for (int i = 0; i < 3; i++) begin
        if (rdv_w[i] != 4'h0) begin
          cnt[i]++;
          if (first[i] < 0) first[i] = c;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rr8_pulses_L%0d", i+1), 32'(cnt[i]), 32'd8);
      chk($sformatf("rr8_latency_L%0d", i+1), 32'(first[i]), 32'(i + 3));
    end

    // Random traffic against the model, then drain.
    for (int c = 0; c < 80; c++)
      step(1, ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
           {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)});
    for (int c = 0; c < 6; c++) step(1, 0, 4'b0000, A2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

- Shares one single-port sprite block ROM among up to four sprite requesters: player, moon, hecatia and laser.
- Uses a round-robin grant, a registered ROM address stage and a tagged return pipeline, so each requester gets back only its own pixel word.
- Sits between the sprite units and the shared sprite ROM instance, in the `clk` domain, under the game FSM's enable.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters
- `ADDR_W`, 16, sprite ROM address width
- `DATA_W`, 12, pixel word width (RGB444)
- `ROM_LAT`, 1, ROM read latency in cycles from `rom_en`/`rom_addr` to `rom_data`

Ports:
- `clk`  in  1  system clock
- `rstn`  in  1  reset; one clock; reset is asynchronous and active-low
- `hold`  in  1  1 = issue no new grants (driven by ~game_en)
- `req`  in  N_REQ  per-requester read request, level
- `addr`  in  N_REQ*ADDR_W  per-requester address, flattened; slice i = [i*ADDR_W +: ADDR_W]
- `gnt`  out  N_REQ  one-hot grant, combinational, at most one bit set
- `rom_en`  out  1  registered ROM enable
- `rom_addr`  out  ADDR_W  registered ROM address
- `rom_data`  in  DATA_W  ROM output
- `rd_valid`  out  N_REQ  one-hot, registered, one-cycle pulse per completed read
- `rd_data`  out  DATA_W  registered read data, qualified by `rd_valid`

## Operation
Arbitration:
- Candidate set is `req & {N_REQ{~hold}}`.
- Search starts at pointer `rr` and wraps modulo N_REQ; the first set bit wins.
- `gnt` is one-hot on the winner, or 0 if there is no candidate.
- On a grant, `rr` becomes winner+1 (wrapping N_REQ-1 -> 0). With no grant, `rr` is unchanged.

Handshake:
- A requester holds `req` and its `addr` stable until it sees `gnt[i]` high at a clock edge.
- A requester that keeps `req` high after a grant is treated as a new request. It re-enters round-robin behind the others; no back-to-back grant to it while others are requesting.

Issue stage (registered):
- On a grant: `rom_en`<=1, `rom_addr`<=addr of winner, `tag0`<=winner index.
- Otherwise `rom_en`<=0 and `rom_addr` holds its value.

Return pipeline:
- Tag and valid are shifted through ROM_LAT stages.
- At the last stage: `rd_valid`<=onehot(tag) if valid, else 0; `rd_data`<=`rom_data` when valid, else held.

`hold`:
- Blocks new grants only.
- Reads already issued complete normally and `rd_valid` still fires.

No back-pressure on the return side:
- The requester must accept `rd_data` in its `rd_valid` cycle.
- One read per cycle is sustained; throughput is 1 word/clk.

Reset (`rstn` low, asynchronous, any time including mid-read):
- `rr`=0, `rom_en`=0, `rom_addr`=0, all pipeline valids=0, `rd_valid`=0, `rd_data`=0.
- Reads in flight are discarded, with no `rd_valid` after release.
- `gnt` is forced to 0 while `rstn` is low.

## Timing
- Grant in cycle t (comb from `req`, `rr`, `hold`).
- `rom_en`/`rom_addr` valid in t+1.
- `rom_data` valid in t+1+ROM_LAT.
- `rd_valid`/`rd_data` valid in t+2+ROM_LAT. With default ROM_LAT=1, `rd_valid` arrives 3 cycles after `gnt`.
- Up to ROM_LAT+1 reads are in flight; completion order equals grant order.
- Simultaneous requests from all four: grants in rr order, one per cycle; each requester is served within N_REQ cycles of asserting `req` (fairness bound).
- `hold` rising in cycle t: no `gnt` in t. `hold` falling: grants resume the same cycle, `rr` unchanged.
- First grant after reset release: index 0 has priority, since `rr`=0.

## Structure
- Shared package `sprite_pkg`:
  - constants `N_SPRITE_REQ`=4, `SPRITE_ADDR_W`=16, `PIXEL_W`=12;
  - requester IDs `REQ_PLAYER`=0, `REQ_MOON`=1, `REQ_HECATIA`=2, `REQ_LASER`=3;
  - transparent-colour constant.
- Sub-module `rr_arbiter`:
  - parameter N; inputs req, ptr; outputs one-hot gnt and winner index;
  - purely combinational, reusable for the bullet pool later.
- The pointer register, issue stage and tag pipeline stay in `sprite_rom_arbiter`.

## Test plan
- Reset, then `req`=0001, addr0=0x0123: `gnt`=0001 in cycle 0; `rom_addr`=0x0123, `rom_en`=1 in cycle 1; `rd_valid`=0001 with `rd_data`=ROM[0x0123] in cycle 3.
- `req`=1111 held for 8 cycles: `gnt` sequence 0001,0010,0100,1000,0001,… and exactly 8 `rd_valid` pulses, each tag matching the grant 3 cycles earlier.
- Requests 0101 with `rr`=1: grant 0100 then 0001; `rr` ends at 1.
- `hold`=1 asserted the cycle after a grant with `req`=1111: no further `gnt`, the pending read still produces one `rd_valid`; `hold`=0 resumes at the next rr index.
- `rstn` pulsed low 1 cycle after a grant: no `rd_valid` for that read; after release, `rr`=0 and the next grant goes to index 0 when `req`=1111.
- Sweep ROM_LAT in {1,2,3} with back-to-back requests: latency = ROM_LAT+2, no lost or duplicated `rd_valid`, at most one `gnt` bit per cycle.
